// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-stage PC generator.
//   pc_state_e  : OFF (in reset) -> BOOT (counting boot edges) -> RUN (fetching)
//   STALL_BIT   : index of the stall-vector bit that freezes the PC
//   BRANCH / NOT_BRANCH, CHIP_ENABLE / CHIP_DISABLE : same values as the
//   existing control-unit defines, so both sides agree on encodings.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2
  } pc_state_e;

  localparam int   STALL_BIT    = 0;
  localparam logic BRANCH       = 1'b1;
  localparam logic NOT_BRANCH   = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: control/branch inputs and fetch outputs of pc_gen.
//   master : control unit / ID side (drives stall, flush, new_pc, branch)
//   slave  : pc_gen (drives ce, pc, redirect_pending_o)
// With PC_ALIGN_CHECK_EN defined, misalign_o / bad_addr_o are also carried.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_address_i;
  logic               ce;
  logic [ADDR_W-1:0]  pc;
  logic               redirect_pending_o;
`ifdef PC_ALIGN_CHECK_EN
  logic               misalign_o;
  logic [ADDR_W-1:0]  bad_addr_o;
`endif

  modport master (
    output stall, flush, new_pc, branch_flag_i, branch_target_address_i,
    input  ce, pc, redirect_pending_o
`ifdef PC_ALIGN_CHECK_EN
    , input misalign_o, bad_addr_o
`endif
  );

  modport slave (
    input  stall, flush, new_pc, branch_flag_i, branch_target_address_i,
    output ce, pc, redirect_pending_o
`ifdef PC_ALIGN_CHECK_EN
    , output misalign_o, bad_addr_o
`endif
  );
endinterface

// File: rtl/pc_redirect_hold.sv
// pc_redirect_hold: one-entry holding register for a branch resolved while
// fetch is stalled.
//   clk, rst    : clock, synchronous active-low reset
//   i_capture   : load i_target and mark valid (latest capture wins)
//   i_clear     : drop any held target (flush / fresh branch)
//   i_consume   : held target has been loaded into the PC
//   o_valid     : a target is held
//   o_target    : the held target
// Clear/consume win over capture.
module pc_redirect_hold #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_capture,
  input  logic              i_clear,
  input  logic              i_consume,
  input  logic [ADDR_W-1:0] i_target,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_target
);
  logic              r_valid;
  logic [ADDR_W-1:0] r_target;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_target <= '0;
    end else if (i_clear || i_consume) begin
      r_valid  <= 1'b0;
    end else if (i_capture) begin
      r_valid  <= 1'b1;
      r_target <= i_target;
    end
  end

  assign o_valid  = r_valid;
  assign o_target = r_target;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: parametrised fetch-stage program counter.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-low reset
//   bus  : pc_gen_if.slave -- stall/flush/new_pc/branch in; ce/pc/
//          redirect_pending_o out (+ misalign_o/bad_addr_o with the macro)
// Optional feature macro: PC_ALIGN_CHECK_EN. When defined, misaligned
// redirect targets are loaded as-is and reported; otherwise the low
// log2(STEP) bits of every redirect target are forced to zero.
// All outputs are registered; nothing combinational from inputs to pc/ce.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                STEP        = 4,
  parameter int                STALL_W     = 6,
  parameter int                BOOT_CYCLES = 1
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  localparam logic [ADDR_W-1:0] W_STEP    = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(STEP - 1);
  localparam logic [3:0]        BOOT_LAST = 4'(BOOT_CYCLES);

  pc_state_e         r_state, w_state_nxt;
  logic [3:0]        r_boot_cnt, w_boot_cnt_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;

  logic              w_run, w_stall, w_branch;
  logic [STALL_W-1:0] w_stall_vec;
  logic              w_unused_stall;
  logic [ADDR_W-1:0] w_flush_tgt, w_br_tgt;
  logic              w_load, w_capture, w_clear, w_consume;
  logic [ADDR_W-1:0] w_load_tgt;
  logic              w_pend_vld;
  logic [ADDR_W-1:0] w_pend_tgt;

  // ---------------- boot FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_OFF;
      r_boot_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_boot_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_boot_cnt_nxt = r_boot_cnt;
    case (r_state)
      ST_OFF: begin
        // first released edge counts as boot edge #1
        w_boot_cnt_nxt = 4'd1;
        w_state_nxt    = (BOOT_CYCLES <= 1) ? ST_RUN : ST_BOOT;
      end
      ST_BOOT: begin
        w_boot_cnt_nxt = r_boot_cnt + 4'd1;
        if (r_boot_cnt + 4'd1 == BOOT_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN:  ;
      default: w_state_nxt = ST_OFF;
    endcase
  end

  assign w_run = (r_state == ST_RUN);

  // ---------------- next-PC selection ----------------
  assign w_stall_vec    = bus.stall;
  assign w_unused_stall = ^w_stall_vec;  // only STALL_BIT matters
  assign w_stall        = w_stall_vec[STALL_BIT];
  assign w_branch       = (bus.branch_flag_i == BRANCH);

`ifdef PC_ALIGN_CHECK_EN
  assign w_flush_tgt = bus.new_pc;
  assign w_br_tgt    = bus.branch_target_address_i;
`else
  assign w_flush_tgt = bus.new_pc & ~LOW_MASK;
  assign w_br_tgt    = bus.branch_target_address_i & ~LOW_MASK;
`endif

  always_comb begin
    w_load     = 1'b0;
    w_load_tgt = w_pend_tgt;
    w_capture  = 1'b0;
    w_clear    = 1'b0;
    w_consume  = 1'b0;
    w_pc_nxt   = r_pc;
    // while ce=0 every input is ignored and pc stays at RESET_PC
    if (w_run) begin
      if (bus.flush) begin
        w_load     = 1'b1;
        w_load_tgt = w_flush_tgt;
        w_clear    = 1'b1;
      end else if (w_stall) begin
        w_capture  = w_branch;
      end else if (w_branch) begin
        w_load     = 1'b1;
        w_load_tgt = w_br_tgt;
        w_clear    = 1'b1;
      end else if (w_pend_vld) begin
        w_load     = 1'b1;
        w_consume  = 1'b1;
      end else begin
        w_pc_nxt   = r_pc + W_STEP;  // wraps modulo 2^ADDR_W
      end
      if (w_load) w_pc_nxt = w_load_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_pc <= RESET_PC;
    else      r_pc <= w_pc_nxt;
  end

  pc_redirect_hold #(.ADDR_W(ADDR_W)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_clear   (w_clear),
    .i_consume (w_consume),
    .i_target  (w_br_tgt),
    .o_valid   (w_pend_vld),
    .o_target  (w_pend_tgt)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic              r_misalign;
  logic [ADDR_W-1:0] r_bad_addr;

  // flagged on the edge the offending target reaches pc, whatever its source
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_misalign <= 1'b0;
      r_bad_addr <= '0;
    end else begin
      r_misalign <= w_load && ((w_load_tgt & LOW_MASK) != '0);
      if (w_load && ((w_load_tgt & LOW_MASK) != '0)) r_bad_addr <= w_load_tgt;
    end
  end

  assign bus.misalign_o = r_misalign;
  assign bus.bad_addr_o = r_bad_addr;
`endif

  assign bus.ce                 = w_run ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.pc                 = r_pc;
  assign bus.redirect_pending_o = w_pend_vld;
endmodule
